// File: rtl/blink_rate_ctrl.sv
// Button-stepped LED clock divider: a debounced press selects the next of four
// half-period presets, applied only at a divider terminal count.
module blink_rate_ctrl #(
    parameter int unsigned COUNT_WIDTH     = 24,
    parameter int unsigned RATE0           = 6000000 - 1,
    parameter int unsigned RATE1           = 3000000 - 1,
    parameter int unsigned RATE2           = 1500000 - 1,
    parameter int unsigned RATE3           = 750000 - 1,
    parameter int unsigned DB_WIDTH        = 17,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    output logic       out,
    output logic [1:0] rate_sel,
    output logic       change_pending
);

    localparam logic [COUNT_WIDTH-1:0] TC0     = COUNT_WIDTH'(RATE0);
    localparam logic [COUNT_WIDTH-1:0] TC1     = COUNT_WIDTH'(RATE1);
    localparam logic [COUNT_WIDTH-1:0] TC2     = COUNT_WIDTH'(RATE2);
    localparam logic [COUNT_WIDTH-1:0] TC3     = COUNT_WIDTH'(RATE3);
    localparam logic [DB_WIDTH-1:0]    DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {RUN, PENDING} state_t;

    state_t                 state, state_nx;
    logic                   btn_m, btn_s;
    logic                   debounced, debounced_d, press;
    logic [DB_WIDTH-1:0]    db_cnt;
    logic [COUNT_WIDTH-1:0] count, tc;
    logic                   wrap;
    logic [1:0]             next_sel, next_sel_nx, rate_sel_nx;

    // Synchroniser, debounce and registered falling-edge (press) detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m       <= 1'b1;
            btn_s       <= 1'b1;
            debounced   <= 1'b1;
            debounced_d <= 1'b1;
            press       <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_m       <= btn_n;
            btn_s       <= btn_m;
            debounced_d <= debounced;
            press       <= debounced_d & ~debounced;
            if (btn_s == debounced) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                debounced <= btn_s;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (rate_sel)
            2'd0:    tc = TC0;
            2'd1:    tc = TC1;
            2'd2:    tc = TC2;
            default: tc = TC3;
        endcase
    end

    assign wrap = (count == tc);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            out   <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            out   <= ~out;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            rate_sel <= 2'd0;
            next_sel <= 2'd0;
        end else begin
            state    <= state_nx;
            rate_sel <= rate_sel_nx;
            next_sel <= next_sel_nx;
        end
    end

    // rate_sel only moves on a wrap, so the running half-period is never cut short.
    always_comb begin
        state_nx    = state;
        next_sel_nx = next_sel;
        rate_sel_nx = rate_sel;
        case (state)
            RUN: begin
                if (press) begin
                    next_sel_nx = rate_sel + 2'd1;
                    state_nx    = PENDING;
                end
            end
            PENDING: begin
                if (press && wrap) begin
                    rate_sel_nx = next_sel + 2'd1;
                    state_nx    = RUN;
                end else if (press) begin
                    next_sel_nx = next_sel + 2'd1;
                end else if (wrap) begin
                    rate_sel_nx = next_sel;
                    state_nx    = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    assign change_pending = (state == PENDING);

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Scoreboard bench for blink_rate_ctrl: two instances (RATE0=9 and RATE0=99)
// share stimulus; a cycle model predicts outputs, plus directed timing checks.
module tb_blink_rate_ctrl;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       out_a, pend_a, out_b, pend_b;
    logic [1:0] sel_a, sel_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    blink_rate_ctrl #(
        .COUNT_WIDTH(4), .RATE0(9), .RATE1(4), .RATE2(2), .RATE3(1),
        .DB_WIDTH(3), .DEBOUNCE_CYCLES(DB)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .out(out_a), .rate_sel(sel_a), .change_pending(pend_a)
    );

    blink_rate_ctrl #(
        .COUNT_WIDTH(7), .RATE0(99), .RATE1(4), .RATE2(2), .RATE3(1),
        .DB_WIDTH(3), .DEBOUNCE_CYCLES(DB)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .out(out_b), .rate_sel(sel_b), .change_pending(pend_b)
    );

    typedef struct {
        logic        s1, s2, lvl, lvl_d, press;
        int unsigned run, cnt;
        logic        out;
        logic [1:0]  sel, nsel;
        logic        pend;
    } mdl_t;

    mdl_t ma, mb;
    int unsigned qa[$], qb[$];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned rate_tc(input logic [1:0] s, input int unsigned r0);
        case (s)
            2'd0:    return r0;
            2'd1:    return 4;
            2'd2:    return 2;
            default: return 1;
        endcase
    endfunction

    function automatic mdl_t step(input mdl_t m, input logic r, input logic b, input int unsigned r0);
        mdl_t n = m;
        logic wr;
        if (r) begin
            n.s1 = 1'b1; n.s2 = 1'b1; n.lvl = 1'b1; n.lvl_d = 1'b1; n.press = 1'b0;
            n.run = 0; n.cnt = 0; n.out = 1'b0; n.sel = 2'd0; n.nsel = 2'd0; n.pend = 1'b0;
            return n;
        end
        n.s1 = b;
        n.s2 = m.s1;
        if (m.s2 == m.lvl) n.run = 0;
        else if (m.run == DB - 1) begin n.lvl = m.s2; n.run = 0; end
        else n.run = m.run + 1;
        n.lvl_d = m.lvl;
        n.press = m.lvl_d & ~m.lvl;
        wr = (m.cnt == rate_tc(m.sel, r0));
        n.cnt = wr ? 0 : m.cnt + 1;
        n.out = wr ? ~m.out : m.out;
        if (!m.pend) begin
            if (m.press) begin n.nsel = 2'(m.sel + 2'd1); n.pend = 1'b1; end
        end else if (m.press && wr) begin
            n.sel = 2'(m.nsel + 2'd1); n.pend = 1'b0;
        end else if (m.press) begin
            n.nsel = 2'(m.nsel + 2'd1);
        end else if (wr) begin
            n.sel = m.nsel; n.pend = 1'b0;
        end
        return n;
    endfunction

    function automatic int unsigned pack(input logic o, input logic [1:0] s, input logic p);
        return 32'({o, s, p});
    endfunction

    // One clock: predict, push, let the DUTs advance, pop and compare.
    task automatic cycle();
        ma = step(ma, rst, btn_n, 9);
        mb = step(mb, rst, btn_n, 99);
        qa.push_back(pack(ma.out, ma.sel, ma.pend));
        qb.push_back(pack(mb.out, mb.sel, mb.pend));
        @(posedge clk);
        #1;
        chk("sb_a", pack(out_a, sel_a, pend_a), qa.pop_front());
        chk("sb_b", pack(out_b, sel_b, pend_b), qb.pop_front());
    endtask

    task automatic measure_half(input bit use_b, output int unsigned n);
        logic prev, cur;
        bit seen = 1'b0;
        int unsigned cnt = 0;
        n = 0;
        prev = use_b ? out_b : out_a;
        for (int k = 0; k < 400; k++) begin
            cycle();
            cur = use_b ? out_b : out_a;
            if (cur != prev) begin
                if (seen) begin n = cnt; return; end
                seen = 1'b1;
                cnt = 1;
                prev = cur;
            end else if (seen) begin
                cnt++;
            end
        end
    endtask

    task automatic press_and_apply(input int unsigned idx, input int unsigned exp_sel,
                                   input int unsigned exp_half);
        int unsigned h;
        int k;
        btn_n = 1'b0;
        repeat (8) cycle();
        btn_n = 1'b1;
        for (k = 0; k < 200 && pend_a; k++) cycle();
        chk($sformatf("t5_applied_%0d", idx), 32'(pend_a), 0);
        chk($sformatf("t5_sel_%0d", idx), 32'(sel_a), exp_sel);
        measure_half(1'b0, h);
        chk($sformatf("t5_half_%0d", idx), h, exp_half);
    endtask

    initial begin
        int unsigned h, lat;
        bit seen;
        int k;

        rst = 1'b1;
        btn_n = 1'b1;
        repeat (3) cycle();
        chk("rst_out", 32'(out_a), 0);
        chk("rst_sel", 32'(sel_a), 0);
        chk("rst_pend", 32'(pend_a), 0);
        rst = 1'b0;

        // Idle: rate 0 half-period is 10 cycles
        repeat (100) cycle();
        chk("t1_sel", 32'(sel_a), 0);
        measure_half(1'b0, h);
        chk("t1_half", h, 10);

        // 3-cycle glitch is filtered
        btn_n = 1'b0;
        repeat (3) cycle();
        btn_n = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            cycle();
            if (pend_a) seen = 1'b1;
        end
        chk("t2_no_pend", 32'(seen), 0);
        chk("t2_sel", 32'(sel_a), 0);
        measure_half(1'b0, h);
        chk("t2_half", h, 10);

        // Single press: 8-cycle latency to change_pending, then rate 1
        repeat (3) cycle();
        btn_n = 1'b0;
        lat = 0;
        for (k = 0; k < 30 && !pend_a; k++) begin
            cycle();
            lat++;
        end
        chk("t3_latency", lat, 8);
        repeat (20 - lat) cycle();
        btn_n = 1'b1;
        for (k = 0; k < 50 && sel_a == 2'd0; k++) cycle();
        chk("t3_sel", 32'(sel_a), 1);
        chk("t3_pend", 32'(pend_a), 0);
        measure_half(1'b0, h);
        chk("t3_half", h, 5);

        // Two presses inside one 100-cycle half-period accumulate
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        btn_n = 1'b0; repeat (6) cycle();
        btn_n = 1'b1; repeat (6) cycle();
        btn_n = 1'b0; repeat (6) cycle();
        btn_n = 1'b1; repeat (6) cycle();
        chk("t4_pend_held", 32'(pend_b), 1);
        chk("t4_sel_held", 32'(sel_b), 0);
        for (k = 0; k < 200 && sel_b == 2'd0; k++) cycle();
        chk("t4_sel", 32'(sel_b), 2);
        chk("t4_pend", 32'(pend_b), 0);
        measure_half(1'b1, h);
        chk("t4_half", h, 3);

        // Four presses walk through every rate and wrap
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        press_and_apply(0, 1, 5);
        press_and_apply(1, 2, 3);
        press_and_apply(2, 3, 2);
        press_and_apply(3, 0, 10);

        // Reset while a change is pending discards it
        btn_n = 1'b0;
        for (k = 0; k < 30 && !pend_a; k++) cycle();
        chk("t6_pend_before", 32'(pend_a), 1);
        rst = 1'b1;
        btn_n = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_out", 32'(out_a), 0);
        chk("t6_sel", 32'(sel_a), 0);
        chk("t6_pend", 32'(pend_a), 0);
        repeat (40) cycle();
        chk("t6_sel_kept", 32'(sel_a), 0);
        chk("t6_pend_kept", 32'(pend_a), 0);
        measure_half(1'b0, h);
        chk("t6_half", h, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
Button-driven controller for the board's LED clock-divider path. It owns one toggling divider output whose half-period is chosen from four preset terminal counts. Each debounced button press steps to the next preset, wrapping after the fourth. A new rate is applied only at a divider terminal count, so `out` never produces a truncated half-period.

Parameters:
COUNT_WIDTH, 24, width of divider counter; must hold the largest RATEn.
RATE0, 6000000-1, terminal count for rate_sel=0 (half-period = RATE0+1 clk cycles).
RATE1, 3000000-1, terminal count for rate_sel=1.
RATE2, 1500000-1, terminal count for rate_sel=2.
RATE3, 750000-1, terminal count for rate_sel=3.
DB_WIDTH, 17, width of debounce counter.
DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a button level change (at least 1).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
btn_n  input  1  raw button, active-low, asynchronous to clk.
out  output  1  divided clock / LED drive.
rate_sel  output  2  index of the preset currently applied to the divider.
change_pending  output  1  high while a requested rate is waiting for the next terminal count.

Behaviour:
- Reset (rst=1 at clock edge):
  - sync flops = 1; debounced level = 1; db_cnt = 0.
  - count = 0; out = 0; rate_sel = 0; next_sel = 0.
  - change_pending = 0; state = RUN.
  - Reset asserted mid-operation discards any pending change; all of the above values appear the cycle after the edge.
- Synchroniser: btn_n passes through two flops to give btn_s.
- Debounce:
  - If btn_s == debounced, db_cnt <= 0.
  - Otherwise db_cnt increments.
  - When btn_s != debounced and db_cnt == DEBOUNCE_CYCLES-1: debounced <= btn_s and db_cnt <= 0.
  - Net effect: debounced follows btn_s after exactly DEBOUNCE_CYCLES consecutive differing cycles. Any shorter glitch is ignored and restarts the count.
- Press event: a single-cycle internal pulse on the cycle after debounced goes 1 -> 0. A release generates no event.
- Divider:
  - Active terminal value TC = RATE[rate_sel].
  - Each cycle: if count == TC, then count <= 0 and out <= ~out; else count <= count+1.
  - count never exceeds TC of the applied rate.
- FSM states: RUN, PENDING.
  - RUN + press: next_sel <= rate_sel+1 (mod 4); change_pending <= 1; go to PENDING.
  - PENDING + press without terminal count: next_sel <= next_sel+1 (mod 4); stay in PENDING. Presses accumulate.
  - PENDING + terminal count without press: rate_sel <= next_sel; change_pending <= 0; go to RUN.
    - The toggle and count reset on this same edge use the old TC.
    - The following half-period uses the new TC.
  - PENDING + press and terminal count on the same cycle: rate_sel <= next_sel+1 (mod 4); change_pending <= 0; go to RUN.
- Invariants:
  - rate_sel changes only on a cycle where count wraps to 0.
  - change_pending == (state == PENDING).
- Latency:
  - btn_n falling edge to press event: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
  - Press event to change_pending high: 1 cycle.
- Wrap-around: 3 -> 0 for both rate_sel and next_sel. Sum arithmetic is 2-bit, with overflow discarded.

Test Plan:
All tests use RATE0=9, RATE1=4, RATE2=2, RATE3=1, DEBOUNCE_CYCLES=4, DB_WIDTH=3, COUNT_WIDTH=4, except test 4.

1. Reset, btn_n held 1 for 100 cycles -> rate_sel=0; change_pending=0; out toggles every 10 cycles starting from 0.
2. btn_n low for 3 cycles, then high -> no press event; change_pending stays 0; rate_sel=0; out period unchanged.
3. btn_n low for 20 cycles mid half-period -> change_pending rises 2+4+2 cycles after the fall. rate_sel goes 0->1 on the edge where count wraps. The half-period in progress is 10 cycles; all following half-periods are 5 cycles.
4. RATE0=99: two clean presses (low 6 / high 6 / low 6) within one half-period -> change_pending held; rate_sel jumps 0->2 at the next wrap; subsequent half-periods are 3 cycles.
5. Four presses, each applied before the next -> rate_sel sequence 1, 2, 3, 0; half-periods 5, 3, 2, 10.
6. rst pulsed for 1 cycle while change_pending=1 -> next cycle out=0, count=0, rate_sel=0, change_pending=0; with no further press, rate 0 resumes and no change is applied.
